// File: rtl/phase_sequencer.sv
// Multi-phase timing controller: owns the slow-clock divider and steps through
// NUM_PHASES phases, each lasting a programmable number of divider ticks.
module phase_sequencer #(
  parameter int NUM_PHASES  = 4,
  parameter int DUR_W       = 8,
  parameter int DEFAULT_DUR = 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic             repeat_mode,
  input  logic             dur_load,
  input  logic [1:0]       dur_idx,
  input  logic [DUR_W-1:0] dur_value,
  input  logic             slow_clk,
  output logic             div_enable,
  output logic             div_reset_n,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic             phase_change,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [1:0] LAST_PHASE = 2'(NUM_PHASES - 1);
  localparam logic [2:0] NUM_PH3    = 3'(NUM_PHASES);

  state_t           state, state_nxt;
  logic [1:0]       phase_nxt;
  logic [DUR_W-1:0] cnt, cnt_nxt;
  logic [DUR_W-1:0] dur_tab [4];
  logic             slow_q, tick, any_zero;
  logic             enter_phase, finish, reject;
  logic             div_enable_nxt, div_reset_n_nxt, phase_valid_nxt, busy_nxt;

  assign tick = slow_clk & ~slow_q;

  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++)
      if (dur_tab[i] == '0) any_zero = 1'b1;
  end

  // State register, datapath registers, registered outputs and duration table
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= '0;
      cnt          <= '0;
      slow_q       <= 1'b0;
      div_enable   <= 1'b0;
      div_reset_n  <= 1'b0;
      phase_valid  <= 1'b0;
      phase_change <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      for (int i = 0; i < 4; i++) dur_tab[i] <= DUR_W'(DEFAULT_DUR);
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      cnt          <= cnt_nxt;
      slow_q       <= slow_clk;
      div_enable   <= div_enable_nxt;
      div_reset_n  <= div_reset_n_nxt;
      phase_valid  <= phase_valid_nxt;
      phase_change <= enter_phase;
      busy         <= busy_nxt;
      done         <= finish;
      err          <= reject;
      // The table only changes in IDLE, so a running pass sees it frozen.
      if (dur_load && state == IDLE && ({1'b0, dur_idx} < NUM_PH3))
        dur_tab[dur_idx] <= dur_value;
    end
  end

  // Next-state and phase/count sequencing
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    cnt_nxt     = cnt;
    enter_phase = 1'b0;
    finish      = 1'b0;
    reject      = 1'b0;
    case (state)
      IDLE: begin
        phase_nxt = '0;
        cnt_nxt   = '0;
        if (!abort && start) begin
          if (any_zero) begin
            reject = 1'b1;
          end else begin
            state_nxt   = RUN;
            cnt_nxt     = dur_tab[0];
            enter_phase = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          phase_nxt = '0;
          cnt_nxt   = '0;
        end else if (pause) begin
          state_nxt = PAUSE;
        end else if (tick) begin
          if (cnt > DUR_W'(1)) begin
            cnt_nxt = cnt - DUR_W'(1);
          end else if (phase != LAST_PHASE) begin
            phase_nxt   = phase + 2'd1;
            cnt_nxt     = dur_tab[phase + 2'd1];
            enter_phase = 1'b1;
          end else if (repeat_mode) begin
            phase_nxt   = '0;
            cnt_nxt     = dur_tab[0];
            enter_phase = 1'b1;
          end else begin
            state_nxt = IDLE;
            phase_nxt = '0;
            cnt_nxt   = '0;
            finish    = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (abort) begin
          state_nxt = IDLE;
          phase_nxt = '0;
          cnt_nxt   = '0;
        end else if (!pause) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Level outputs follow the state being entered; the divider runs only in RUN
  always_comb begin
    div_enable_nxt  = (state_nxt == RUN);
    div_reset_n_nxt = (state_nxt != IDLE);
    phase_valid_nxt = (state_nxt != IDLE);
    busy_nxt        = (state_nxt != IDLE);
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Multi-phase timing controller that sequences the shared slow-clock divider.
- Owns the divider's enable and reset. Counts rising edges of the divider output as ticks and steps through NUM_PHASES phases, each lasting a programmable number of ticks.
- Drives phase indication to downstream controllers, such as state-indicator or light-control logic.
- Supports start, pause, abort and continuous repeat.

Parameters:
- NUM_PHASES, 4, number of phases; 2..4 supported, index width fixed at 2 bits.
- DUR_W, 8, width of each phase duration, in ticks.
- DEFAULT_DUR, 1, reset value of every duration table entry; must be nonzero.

Ports:
- clk_in  input  1  system clock; also clocks the divider.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin the sequence; honoured only in IDLE.
- abort  input  1  level; terminates the sequence.
- pause  input  1  level; freezes the sequence while high.
- repeat  input  1  level, sampled at end of the last phase; 1 = loop back to phase 0.
- dur_load  input  1  write strobe for the duration table.
- dur_idx  input  2  table entry to write.
- dur_value  input  DUR_W  duration written, in ticks.
- slow_clk  input  1  divider output; same clock domain, no synchroniser.
- div_enable  output  1  divider enable.
- div_reset_n  output  1  divider reset, active-low.
- phase  output  2  current phase index.
- phase_valid  output  1  phase is meaningful (RUN or PAUSE).
- phase_change  output  1  one-cycle pulse on entry to any phase.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse when the sequence completes.
- err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Clocking: one clock, clk_in. reset is synchronous, active-high; all state updates on posedge clk_in.
- Reset values:
  - state=IDLE, phase=0, cnt=0, slow_q=0.
  - div_enable=0, div_reset_n=0.
  - phase_valid=0, phase_change=0, busy=0, done=0, err=0.
  - All table entries = DEFAULT_DUR.
  - Reset mid-sequence has the same effect.
- Tick: tick = slow_clk & ~slow_q, with slow_q registering slow_clk every cycle.
- Duration table:
  - A write occurs when dur_load=1, state is IDLE and dur_idx < NUM_PHASES.
  - Otherwise the write is ignored.
- States: IDLE, RUN, PAUSE. All outputs are registered.
- IDLE:
  - div_enable=0, div_reset_n=0, so the divider is held cleared.
  - If abort=1, stay in IDLE; abort wins over start.
  - Else if start=1 and any entry [0..NUM_PHASES-1] is 0: err=1 next cycle, stay in IDLE.
  - Else if start=1: next cycle enter RUN with phase=0, cnt=dur[0], phase_change=1, busy=1, phase_valid=1, div_reset_n=1, div_enable=1.
- RUN:
  - abort: next cycle IDLE, all outputs at reset values, done=0.
  - Else pause: next cycle PAUSE, div_enable=0. A tick in that same cycle is discarded.
  - Else tick with cnt>1: cnt decrements by 1.
  - Else tick with cnt==1 and phase<NUM_PHASES-1: phase increments, cnt=dur[phase+1], phase_change=1.
  - Else tick with cnt==1 on the last phase:
    - repeat=1: phase=0, cnt=dur[0], phase_change=1, no done.
    - repeat=0: next cycle IDLE with done=1, busy=0, phase_valid=0, div_enable=0, div_reset_n=0.
- PAUSE:
  - div_enable=0, div_reset_n=1; phase and cnt are held.
  - Ticks are ignored; slow_q still tracks slow_clk.
  - abort: next cycle IDLE.
  - pause=0: next cycle RUN, div_enable=1, no phase_change.
- Latency:
  - Phase k lasts exactly dur[k] ticks.
  - The phase advances on the cycle after the qualifying tick.
  - start to phase_valid: 1 cycle.
- start while busy is ignored.
- Table writes while busy are ignored; a repeat pass uses the table as frozen at start.

Test Plan:
- Normal sequence:
  - Stimulus: dur={3,1,2,1}; bench drives slow_clk high 1 cycle in every 4; start.
  - Response: phase 0→1→2→3 after 3, 1, 2 and 1 ticks respectively.
  - Response: phase_change pulses 4 times; done pulses once, 1 cycle after the 7th tick; div_enable falls with it.
- Zero duration: dur[2]=0, then start → err=1 for exactly 1 cycle; busy stays 0; div_reset_n stays 0.
- Pause:
  - Stimulus: in phase 1 with cnt=2, hold pause for 12 cycles spanning 3 ticks.
  - Response: phase and cnt are unchanged and div_enable=0 throughout the pause.
  - Response: after release, phase 1 ends 2 ticks later.
- Abort: abort in phase 2 → next cycle busy=0, phase_valid=0, done=0, div_reset_n=0. Start with abort in the same cycle → stays IDLE.
- Repeat:
  - Stimulus: repeat=1; let phase 3 end.
  - Response: phase=0 with phase_change and no done.
  - Stimulus: drop repeat.
  - Response: done after the next phase 3.
- Write protection and reset:
  - Stimulus: dur_load while busy.
  - Response: durations unchanged on the next pass.
  - Stimulus: reset in phase 1.
  - Response: all outputs at reset values next cycle; table back to DEFAULT_DUR.
